// File: rtl/rand_burst_ctrl_pkg.sv
// Shared definitions for the WiMAX burst randomizer controller:
// FSM encodings, IV field layout and the padding value.
package rand_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam int IV_W         = 15;
  localparam int IV_BSID_LSB  = 11;
  localparam int IV_UIUC_LSB  = 5;
  localparam int IV_FRAME_LSB = 0;

  // Bits 10:9 and bit 4 of the IV are always set.
  localparam logic [IV_W-1:0] IV_FIXED = 15'h0610;

  localparam logic PAD_BIT = 1'b1;

  function automatic logic [IV_W-1:0] gen_rand_iv(
    input logic [3:0] bsid,
    input logic [3:0] uiuc,
    input logic [3:0] frame
  );
    logic [IV_W-1:0] iv;
    iv                        = IV_FIXED;
    iv[IV_BSID_LSB  +: 4]     = bsid;
    iv[IV_UIUC_LSB  +: 4]     = uiuc;
    iv[IV_FRAME_LSB +: 4]     = frame;
    return iv;
  endfunction

endpackage

// File: rtl/rand_burst_ctrl.sv
// Per-burst sequencer for the OFDM randomizer: IV reload, source streaming,
// all-ones padding up to the burst length and completion tracking.
module rand_burst_ctrl
  import rand_burst_ctrl_pkg::*;
#(
  parameter int W  = 1,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          desc_valid,
  output logic          desc_ready,
  input  logic [3:0]    desc_bsid,
  input  logic [3:0]    desc_uiuc,
  input  logic [3:0]    desc_frame,
  input  logic [LW-1:0] desc_data_len,
  input  logic [LW-1:0] desc_total_len,
  input  logic [W-1:0]  src_bits,
  input  logic          src_valid,
  output logic          src_ready,
  output logic [W-1:0]  rnd_in_bits,
  output logic          rnd_in_valid,
  output logic [14:0]   rnd_iv,
  output logic          rnd_reload,
  input  logic          rnd_out_valid,
  output logic          busy,
  output logic          burst_done,
  output logic          err_len
);

  state_t        state_q, state_d;
  logic [3:0]    bsid_q, bsid_d;
  logic [3:0]    uiuc_q, uiuc_d;
  logic [3:0]    frame_q, frame_d;
  logic [LW-1:0] data_len_q, data_len_d;
  logic [LW-1:0] total_len_q, total_len_d;
  logic [LW-1:0] in_cnt_q, in_cnt_d;
  logic [LW-1:0] out_cnt_q, out_cnt_d;
  logic [W-1:0]  in_bits_q, in_bits_d;
  logic          in_valid_q, in_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic desc_fire;
  logic src_fire;
  logic out_counted;

  assign desc_fire   = desc_valid && desc_ready;
  assign src_fire    = src_valid && src_ready;
  assign out_counted = rnd_out_valid && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bsid_q      <= '0;
      uiuc_q      <= '0;
      frame_q     <= '0;
      data_len_q  <= '0;
      total_len_q <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      in_bits_q   <= '0;
      in_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bsid_q      <= bsid_d;
      uiuc_q      <= uiuc_d;
      frame_q     <= frame_d;
      data_len_q  <= data_len_d;
      total_len_q <= total_len_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      in_bits_q   <= in_bits_d;
      in_valid_q  <= in_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bsid_d      = bsid_q;
    uiuc_d      = uiuc_q;
    frame_d     = frame_q;
    data_len_d  = data_len_q;
    total_len_d = total_len_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_counted ? out_cnt_q + LW'(1) : out_cnt_q;
    in_bits_d   = '0;
    in_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (desc_fire) begin
          if (desc_data_len > desc_total_len) begin
            err_d = 1'b1;
          end else if (desc_total_len == '0) begin
            done_d = 1'b1;
          end else begin
            bsid_d      = desc_bsid;
            uiuc_d      = desc_uiuc;
            frame_d     = desc_frame;
            data_len_d  = desc_data_len;
            total_len_d = desc_total_len;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        if (src_fire) begin
          in_bits_d  = src_bits;
          in_valid_d = 1'b1;
          in_cnt_d   = in_cnt_q + LW'(1);
        end else if ((in_cnt_q >= data_len_q) && (in_cnt_q < total_len_q)) begin
          // Source exhausted: fill the remainder of the burst with ones.
          in_bits_d  = {W{PAD_BIT}};
          in_valid_d = 1'b1;
          in_cnt_d   = in_cnt_q + LW'(1);
        end
        if (in_cnt_d == total_len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_d >= total_len_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    desc_ready = (state_q == ST_IDLE);
    src_ready  = (state_q == ST_STREAM) && (in_cnt_q < data_len_q);
    busy       = (state_q != ST_IDLE);
    rnd_reload = (state_q == ST_LOAD);
    rnd_iv     = (state_q == ST_LOAD) ? gen_rand_iv(bsid_q, uiuc_q, frame_q) : 15'd0;
  end

  assign rnd_in_bits  = in_bits_q;
  assign rnd_in_valid = in_valid_q;
  assign burst_done   = done_q;
  assign err_len      = err_q;

endmodule

// File: tb/tb_rand_burst_ctrl.sv
// Scoreboard bench for rand_burst_ctrl: directed scenarios plus random bursts,
// with a small randomizer model returning out_valid after a random delay.
module tb_rand_burst_ctrl;

  localparam int W  = 1;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [3:0]    desc_bsid = '0;
  logic [3:0]    desc_uiuc = '0;
  logic [3:0]    desc_frame = '0;
  logic [LW-1:0] desc_data_len = '0;
  logic [LW-1:0] desc_total_len = '0;
  logic [W-1:0]  src_bits = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [W-1:0]  rnd_in_bits;
  logic          rnd_in_valid;
  logic [14:0]   rnd_iv;
  logic          rnd_reload;
  logic          rnd_out_valid = 1'b0;
  logic          busy;
  logic          burst_done;
  logic          err_len;

  rand_burst_ctrl #(.W(W), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_bsid(desc_bsid), .desc_uiuc(desc_uiuc), .desc_frame(desc_frame),
    .desc_data_len(desc_data_len), .desc_total_len(desc_total_len),
    .src_bits(src_bits), .src_valid(src_valid), .src_ready(src_ready),
    .rnd_in_bits(rnd_in_bits), .rnd_in_valid(rnd_in_valid),
    .rnd_iv(rnd_iv), .rnd_reload(rnd_reload), .rnd_out_valid(rnd_out_valid),
    .busy(busy), .burst_done(burst_done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] word;
    bit           is_data;
  } exp_word_t;

  exp_word_t    exp_words[$];
  int           hs_cyc[$];
  logic [14:0]  exp_iv[$];
  int           exp_evt[$];     // 1 = burst_done, 2 = err_len
  logic [W-1:0] src_data[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int pending   = 0;
  int emitted   = 0;
  int cur_tlen  = 0;
  bit noise_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Randomizer stand-in: each accepted input word comes back as one out_valid
  // at least a cycle later; noise pulses are injected only while idle.
  initial forever begin
    @(posedge clk);
    #2;
    if (!reset) begin
      pending       = 0;
      rnd_out_valid = 1'b0;
    end else begin
      if (pending > 0) begin
        rnd_out_valid = ($urandom_range(0, 3) != 0);
        if (rnd_out_valid) begin
          pending--;
          emitted++;
        end
      end else begin
        rnd_out_valid = noise_en && ($urandom_range(0, 1) == 1);
      end
      if (rnd_in_valid) pending++;
    end
  end

  // Monitor: compares every DUT presentation against the queued expectations.
  initial forever begin
    exp_word_t e;
    @(negedge clk);
    if (reset) begin
      if (rnd_reload) begin
        check("reload_busy", busy, 1);
        check("reload_expected", exp_iv.size() != 0, 1);
        if (exp_iv.size() != 0) check("rnd_iv", rnd_iv, exp_iv.pop_front());
      end else begin
        check("rnd_iv_zero_outside_load", rnd_iv, 0);
      end
      if (rnd_in_valid) begin
        check("word_expected", exp_words.size() != 0, 1);
        if (exp_words.size() != 0) begin
          e = exp_words.pop_front();
          check("rnd_in_bits", rnd_in_bits, e.word);
          if (e.is_data) begin
            check("data_has_handshake", hs_cyc.size() != 0, 1);
            if (hs_cyc.size() != 0) check("data_latency_cycle", cyc, hs_cyc.pop_front() + 1);
          end
        end
      end
      if (burst_done) begin
        check("done_expected", exp_evt.size() != 0, 1);
        if (exp_evt.size() != 0) check("done_event_kind", burst_done ? exp_evt.pop_front() : 0, 1);
        check("done_all_words_sent", exp_words.size(), 0);
        check("done_after_all_outputs", emitted, cur_tlen);
        done_seen++;
      end
      if (err_len) begin
        check("err_expected", exp_evt.size() != 0, 1);
        if (exp_evt.size() != 0) check("err_event_kind", err_len ? exp_evt.pop_front() : 0, 2);
        err_seen++;
      end
    end
  end

  // Reference model: what one descriptor must produce, from the burst rules alone.
  task automatic expect_burst(input int bsid, input int uiuc, input int frame,
                              input int dlen, input int tlen);
    exp_word_t e;
    if (dlen > tlen) begin
      exp_evt.push_back(2);
    end else if (tlen == 0) begin
      exp_evt.push_back(1);
    end else begin
      exp_iv.push_back(15'(bsid * 2048 + 3 * 512 + uiuc * 32 + 16 + frame));
      for (int i = 0; i < tlen; i++) begin
        e.is_data = (i < dlen);
        e.word    = (i < dlen) ? src_data[i] : {W{1'b1}};
        exp_words.push_back(e);
      end
      exp_evt.push_back(1);
    end
  endtask

  // All main-thread tasks start and end at posedge+1.
  task automatic issue_desc(input int bsid, input int uiuc, input int frame,
                            input int dlen, input int tlen);
    int t = 0;
    while (!desc_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("desc_ready_before_issue", desc_ready, 1);
    noise_en       = 1'b0;
    emitted        = 0;
    cur_tlen       = (dlen > tlen) ? 0 : tlen;
    desc_valid     = 1'b1;
    desc_bsid      = 4'(bsid);
    desc_uiuc      = 4'(uiuc);
    desc_frame     = 4'(frame);
    desc_data_len  = LW'(dlen);
    desc_total_len = LW'(tlen);
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic feed(input int mode, input int max_hs);
    int  i = 0;
    int  t = 0;
    bit  hs;
    while (i < max_hs && t < 2000) begin
      case (mode)
        0:       src_valid = 1'b1;
        1:       src_valid = (t % 3 == 0);
        default: src_valid = ($urandom_range(0, 1) == 1);
      endcase
      src_bits = src_data[i];
      #1;
      hs = src_valid && src_ready;
      if (hs) hs_cyc.push_back(cyc);
      @(posedge clk); #1;
      if (hs) i++;
      t++;
    end
    src_valid = 1'b0;
    check("src_handshakes", i, max_hs);
  endtask

  task automatic run_burst(input int bsid, input int uiuc, input int frame,
                           input int dlen, input int tlen, input int mode, input int gap);
    int d0, e0, t;
    noise_en = 1'b1;
    repeat (gap) begin @(posedge clk); #1; end
    src_data.delete();
    for (int i = 0; i < dlen; i++) src_data.push_back(W'($urandom));
    expect_burst(bsid, uiuc, frame, dlen, tlen);
    d0 = done_seen;
    e0 = err_seen;
    issue_desc(bsid, uiuc, frame, dlen, tlen);
    if (dlen <= tlen && tlen > 0) begin
      feed(mode, dlen);
      check("src_ready_low_after_data", src_ready, 0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        check("busy_low_no_burst", busy, 0);
        @(posedge clk); #1;
      end
    end
    t = 0;
    while (done_seen == d0 && err_seen == e0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("burst_finished_in_time", (done_seen != d0) || (err_seen != e0), 1);
  endtask

  initial begin
    int dl, tl;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_desc_ready", desc_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_rnd_in_valid", rnd_in_valid, 0);
    check("reset_rnd_reload", rnd_reload, 0);
    check("reset_rnd_iv", rnd_iv, 0);
    check("reset_src_ready", src_ready, 0);
    check("reset_done_err", {burst_done, err_len}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    run_burst(5, 7, 3, 8, 8, 0, 1);
    run_burst(2, 9, 1, 4, 10, 0, 0);
    run_burst(6, 1, 8, 7, 9, 1, 2);
    run_burst(1, 2, 3, 5, 3, 0, 1);
    run_burst(1, 2, 3, 0, 0, 0, 1);

    // Reset in the middle of a stream after three words.
    src_data.delete();
    for (int i = 0; i < 8; i++) src_data.push_back(W'($urandom));
    expect_burst(10, 4, 2, 8, 8);
    issue_desc(10, 4, 2, 8, 8);
    feed(0, 3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_rnd_in_valid", rnd_in_valid, 0);
    check("midreset_src_ready", src_ready, 0);
    check("midreset_desc_ready", desc_ready, 1);
    check("midreset_done", burst_done, 0);
    exp_words.delete();
    hs_cyc.delete();
    exp_evt.delete();
    exp_iv.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("after_reset_desc_ready", desc_ready, 1);
    run_burst(12, 5, 9, 3, 6, 2, 0);

    // Back-to-back bursts, frame 3 then frame 4.
    run_burst(5, 7, 3, 6, 7, 0, 0);
    run_burst(5, 7, 4, 5, 5, 0, 0);

    for (int n = 0; n < 25; n++) begin
      tl = $urandom_range(0, 12);
      dl = ($urandom_range(0, 9) == 0) ? tl + $urandom_range(1, 3) : $urandom_range(0, tl);
      run_burst($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                dl, tl, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    repeat (5) begin @(posedge clk); #1; end
    check("final_words_empty", exp_words.size(), 0);
    check("final_iv_empty", exp_iv.size(), 0);
    check("final_events_empty", exp_evt.size(), 0);
    check("final_handshakes_empty", hs_cyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
